// File: rtl/bp_cfg_param_responder_pkg.sv
// Processor parameter table: configuration IDs, the per-config field record,
// and the index-to-field lookup used by the read-side responder.
package bp_cfg_param_responder_pkg;

  typedef enum logic [3:0] {
    e_bp_inv_cfg         = 4'd0,
    e_bp_half_core_cfg   = 4'd1,
    e_bp_single_core_cfg = 4'd2,
    e_bp_dual_core_cfg   = 4'd3,
    e_bp_quad_core_cfg   = 4'd4,
    e_bp_oct_core_cfg    = 4'd5,
    e_bp_sexta_core_cfg  = 4'd6
  } bp_params_e;

  localparam int num_fields_lp = 39;

  typedef enum logic [5:0] {
    e_fld_cc_x_dim, e_fld_cc_y_dim, e_fld_ic_y_dim, e_fld_mc_y_dim, e_fld_ac_x_dim,
    e_fld_vaddr_width, e_fld_paddr_width, e_fld_asid_width,
    e_fld_branch_metadata_fwd_width, e_fld_btb_tag_width, e_fld_btb_idx_width,
    e_fld_bht_idx_width, e_fld_ras_idx_width,
    e_fld_itlb_els, e_fld_dtlb_els,
    e_fld_lce_sets, e_fld_lce_assoc, e_fld_cce_block_width, e_fld_cce_pc_width,
    e_fld_l2_sets, e_fld_l2_assoc,
    e_fld_fe_queue_fifo_els, e_fld_fe_cmd_fifo_els,
    e_fld_coh_noc_async_clk, e_fld_coh_noc_max_credits, e_fld_coh_noc_flit_width,
    e_fld_coh_noc_cid_width, e_fld_coh_noc_len_width,
    e_fld_mem_noc_async_clk, e_fld_mem_noc_max_credits, e_fld_mem_noc_flit_width,
    e_fld_mem_noc_cid_width, e_fld_mem_noc_len_width,
    e_fld_io_noc_async_clk, e_fld_io_noc_did_width, e_fld_io_noc_max_credits,
    e_fld_io_noc_flit_width, e_fld_io_noc_cid_width, e_fld_io_noc_len_width,
    e_fld_params_id = 6'd63
  } bp_param_field_e;

  // Member order matches the field indices, so field k sits at a fixed slice.
  typedef struct packed {
    int unsigned cc_x_dim, cc_y_dim, ic_y_dim, mc_y_dim, ac_x_dim;
    int unsigned vaddr_width, paddr_width, asid_width;
    int unsigned branch_metadata_fwd_width, btb_tag_width, btb_idx_width;
    int unsigned bht_idx_width, ras_idx_width;
    int unsigned itlb_els, dtlb_els;
    int unsigned lce_sets, lce_assoc, cce_block_width, cce_pc_width;
    int unsigned l2_sets, l2_assoc;
    int unsigned fe_queue_fifo_els, fe_cmd_fifo_els;
    int unsigned coh_noc_async_clk, coh_noc_max_credits, coh_noc_flit_width;
    int unsigned coh_noc_cid_width, coh_noc_len_width;
    int unsigned mem_noc_async_clk, mem_noc_max_credits, mem_noc_flit_width;
    int unsigned mem_noc_cid_width, mem_noc_len_width;
    int unsigned io_noc_async_clk, io_noc_did_width, io_noc_max_credits;
    int unsigned io_noc_flit_width, io_noc_cid_width, io_noc_len_width;
    int unsigned param_id;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_single_core_cfg_p = '{
    cc_x_dim: 1, cc_y_dim: 1, ic_y_dim: 1, mc_y_dim: 1, ac_x_dim: 0,
    vaddr_width: 39, paddr_width: 40, asid_width: 1,
    branch_metadata_fwd_width: 36, btb_tag_width: 10, btb_idx_width: 6,
    bht_idx_width: 9, ras_idx_width: 2,
    itlb_els: 8, dtlb_els: 8,
    lce_sets: 64, lce_assoc: 8, cce_block_width: 512, cce_pc_width: 8,
    l2_sets: 128, l2_assoc: 8,
    fe_queue_fifo_els: 8, fe_cmd_fifo_els: 4,
    coh_noc_async_clk: 0, coh_noc_max_credits: 8, coh_noc_flit_width: 128,
    coh_noc_cid_width: 2, coh_noc_len_width: 3,
    mem_noc_async_clk: 0, mem_noc_max_credits: 8, mem_noc_flit_width: 64,
    mem_noc_cid_width: 2, mem_noc_len_width: 4,
    io_noc_async_clk: 0, io_noc_did_width: 1, io_noc_max_credits: 16,
    io_noc_flit_width: 64, io_noc_cid_width: 1, io_noc_len_width: 4,
    param_id: 2
  };

  function automatic bp_proc_param_s bp_proc_param_get(input bp_params_e cfg);
    bp_proc_param_s p;
    p = bp_single_core_cfg_p;
    if (cfg == e_bp_sexta_core_cfg) begin
      p.cc_x_dim = 4;
      p.cc_y_dim = 4;
    end
    p.param_id = 32'(cfg);
    return p;
  endfunction

  // Returns {err, data[30:0]}; unmapped indices give err=1 and zero data.
  function automatic logic [31:0] bp_param_field_get(input bp_proc_param_s p,
                                                     input logic [5:0] idx);
    logic [$bits(bp_proc_param_s)-1:0] flat;
    logic [31:0] res;
    flat = p;
    if (idx == e_fld_params_id)
      res = {1'b0, p.param_id[30:0]};
    else if (idx < 6'(num_fields_lp))
      res = {1'b0, flat[(num_fields_lp - int'(idx)) * 32 +: 31]};
    else
      res = {1'b1, 31'd0};
    return res;
  endfunction

endpackage

// File: rtl/bp_cfg_param_resp_fifo.sv
// Two-entry response buffer: valid/ready in, valid/yumi out, accepts a push
// in the same cycle as a pop even when full.
module bp_cfg_param_resp_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o
);
  logic [width_p-1:0] mem_q [2];
  logic       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign v_o     = (count_q != 2'd0);
  assign ready_o = (count_q != 2'd2) | yumi_i;
  assign data_o  = mem_q[rptr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_comb begin
    wptr_d  = wptr_q ^ push;
    rptr_d  = rptr_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wptr_q] <= data_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/bp_cfg_param_responder.sv
// Parameter-table read responder: serves build-time config fields by index,
// single-beat or burst, through a two-entry response buffer.
module bp_cfg_param_responder
  import bp_cfg_param_responder_pkg::*;
#(
  parameter bp_params_e bp_params_p  = e_bp_single_core_cfg,
  parameter int         data_width_p = 32,
  parameter int         idx_width_p  = 6,
  parameter int         len_width_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    req_v_i,
  output logic                    req_ready_o,
  input  logic [idx_width_p-1:0]  req_idx_i,
  input  logic [len_width_p-1:0]  req_len_i,
  output logic                    resp_v_o,
  input  logic                    resp_yumi_i,
  output logic [data_width_p-1:0] resp_data_o,
  output logic [idx_width_p-1:0]  resp_idx_o,
  output logic                    resp_err_o,
  output logic                    resp_last_o,
  output logic                    busy_o
);
  localparam bp_proc_param_s proc_param_lp  = bp_proc_param_get(bp_params_p);
  localparam int             entry_width_lp = data_width_p + idx_width_p + 2;

  typedef enum logic [0:0] {e_idle, e_burst} state_e;

  state_e                    state_q, state_d;
  logic [idx_width_p-1:0]    idx_q, idx_d;
  logic [len_width_p-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic                      ready_en_q;
  logic                      push_v, fifo_ready;
  logic [31:0]               field_w;
  logic [entry_width_lp-1:0] push_data, pop_data;

  assign field_w     = bp_param_field_get(proc_param_lp, 6'(idx_q));
  assign push_data   = {data_width_p'(field_w[30:0]), idx_q, field_w[31], (cnt_q == len_q)};
  // Held low through reset and for the first edge after it.
  assign req_ready_o = (state_q == e_idle) & ready_en_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    push_v  = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (req_v_i && req_ready_o) begin
          idx_d   = req_idx_i;
          len_d   = req_len_i;
          cnt_d   = '0;
          state_d = e_burst;
        end
      end
      e_burst: begin
        push_v = 1'b1;
        if (fifo_ready) begin
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q) state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  bp_cfg_param_resp_fifo #(.width_p(entry_width_lp)) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (push_v),
    .ready_o   (fifo_ready),
    .data_i    (push_data),
    .v_o       (resp_v_o),
    .yumi_i    (resp_yumi_i),
    .data_o    (pop_data)
  );

  assign {resp_data_o, resp_idx_o, resp_err_o, resp_last_o} = pop_data;
  assign busy_o = (state_q != e_idle) | resp_v_o;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(resp_yumi_i && !resp_v_o));
endmodule
